uart_seq_checker: RTL and testbench
===================================

// Module: uart_seq_checker
// PURPOSE
//  Synthesizable UART receiver plus on-the-fly expected-sequence checker for on-chip self-test.
//  Deserializes frames from the core's uart_tx_line and compares each byte to an internally
//  generated Fibonacci sequence (1,1,2,3,5,...). Reports a pass/fail verdict, so board bring-up
//  needs no host-side checker. Generalises the fixed 8N1 bench receiver: width, baud divisor,
//  parity, stop bits and sequence length are parameters; adds framing/parity/false-start detection.
// PARAMETERS
//  DATA_WIDTH    8   data bits per frame, LSB first; also the Fibonacci register width.
//  CLKS_PER_BIT  4   clk cycles per bit; must be >= 4 and even.
//  PARITY        0   0 none, 1 even, 2 odd.
//  STOP_BITS     1   1 or 2.
//  EXPECT_CNT    12  matching frames required for pass; >= 1.
// PORTS
//  clk           in   1                    single clock; all state updates on posedge.
//  reset         in   1                    synchronous, active-high.
//  rx            in   1                    serial line, idle high; asynchronous to clk.
//  rx_data       out  DATA_WIDTH           last received data; held until next frame.
//  rx_valid      out  1                    1-cycle pulse per completed frame (good or bad).
//  frame_err     out  1                    sticky: a stop bit sampled 0.
//  parity_err    out  1                    sticky: parity mismatch (PARITY != 0 only).
//  mismatch      out  1                    sticky: good frame != expected value.
//  fail_idx      out  $clog2(EXPECT_CNT+1) index of first failing frame; valid when done & !pass.
//  match_cnt     out  $clog2(EXPECT_CNT+1) matching frames so far.
//  done          out  1                    sticky: verdict reached.
//  pass          out  1                    sticky: EXPECT_CNT matches, no error.
// BEHAVIOUR
//  Reset: all outputs 0; FSM IDLE; generator (cur,prev) = (1,0); baud and bit counters 0.
//  Reset mid-frame: frame discarded; no rx_valid; no error flagged.
//  rx passes a 2-flop synchronizer, initialised to 1 on reset. Only the synchronized bit is sampled.
//  FSM states: IDLE, START, DATA, PAR, STOP, CHECK.
//   IDLE: a synchronized-rx falling edge goes to START; baud counter loads CLKS_PER_BIT/2-1.
//   START: at counter 0 (mid start bit), rx==1 means a false start: back to IDLE, no flags.
//          rx==0 goes to DATA; counter reloads CLKS_PER_BIT-1.
//   DATA: samples at each counter expiry into bit [bit_cnt]; bit_cnt 0..DATA_WIDTH-1.
//         After the last bit: PAR if PARITY != 0, else STOP.
//   PAR: samples one bit. Even parity: XOR(data, parity bit) must be 0. Odd parity: it must be 1.
//   STOP: samples STOP_BITS bits. Any 0 sets frame_err. The frame is done at the last stop sample.
//   CHECK: one cycle. Updates rx_data, pulses rx_valid, runs the compare. Returns to IDLE.
//         A start edge arriving during CHECK must not be lost; the edge detect is registered.
//  Latency: rx_valid rises 1 clk after the final stop-bit mid-sample (~CLKS_PER_BIT/2+1 clk after
//   the stop bit starts, plus 2 sync cycles).
//  Compare, only while !done:
//   Frame with frame_err or parity_err: done=1, pass=0, fail_idx=match_cnt; no value compare.
//   rx_data == cur: match_cnt++; generator steps (cur,prev) <= (cur+prev, cur), wrapping mod
//    2^DATA_WIDTH. When match_cnt reaches EXPECT_CNT: done=1, pass=1.
//   rx_data != cur: mismatch=1, done=1, pass=0, fail_idx=match_cnt.
//  After done: the receiver keeps running and rx_valid/rx_data still update.
//   Checker state and sticky flags are frozen until reset.
//  A line held low (break) produces one frame with frame_err. No new frame starts until rx
//   returns high and falls again.
// STRUCTURE
//  Shared header uart_defs.vh holds the PARITY_NONE/EVEN/ODD codes and the FSM state encodings.
//  Sub-module uart_rx_core: synchronizer, baud counter and FSM.
//   Outputs: data, valid, frame_err, parity_err.
//   Parameters: DATA_WIDTH, CLKS_PER_BIT, PARITY, STOP_BITS.
//  The top level holds the Fibonacci generator, compare logic, counters and sticky flags.
// TESTING  (bench drives rx at CLKS_PER_BIT; default parameters unless stated)
//  1 Send 1,1,2,3,5,8,13,21,34,55,89,144 in 8N1 -> 12 rx_valid pulses; match_cnt=12; done=1; pass=1.
//  2 Send 1,1,2,4 -> mismatch=1, done=1, pass=0, fail_idx=3, match_cnt=3.
//    A 5th frame 0x05 still pulses rx_valid with rx_data=0x05; match_cnt stays 3.
//  3 Frame 0x01 with stop bit 0 -> frame_err=1, done=1, pass=0, fail_idx=0.
//  4 Glitch low for 1 clk, then idle; then a valid frame 0x01 -> no frame from the glitch.
//    Then rx_valid with 0x01; match_cnt=1.
//  5 PARITY=1, EXPECT_CNT=3: send 1,1 with correct parity, then 2 with inverted parity bit
//    -> parity_err=1; fail_idx=2; pass=0.
//  6 Assert reset mid-DATA of frame 2 of scenario 1, then resend the full sequence -> no rx_valid
//    for the aborted frame; all flags 0 after reset; final pass=1.

Source files
------------

// File: rtl/uart_seq_checker_pkg.sv
// Shared definitions for the UART sequence checker: parity modes, receiver states
// and the parity error helper.
package uart_seq_checker_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_PAR   = 3'd3,
    ST_STOP  = 3'd4,
    ST_CHECK = 3'd5
  } rx_state_e;

  // sum is the XOR of all data bits and the received parity bit
  function automatic logic parity_bad(input int mode, input logic sum);
    case (mode)
      PARITY_EVEN: return sum;
      PARITY_ODD:  return ~sum;
      default:     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_seq_checker_rx_core.sv
// UART receiver: 2-flop synchronizer, mid-bit sampling baud counter and frame FSM.
// Reports each completed frame with its data and per-frame framing/parity flags.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_IDLE  | line idle, waiting for a falling edge (or a pending one)
//   ST_START | counting to mid start bit; high there means false start
//   ST_DATA  | sampling DATA_WIDTH bits, LSB first
//   ST_PAR   | sampling the parity bit
//   ST_STOP  | sampling STOP_BITS stop bits; any low sets the frame error
//   ST_CHECK | one cycle: frame result presented, valid pulses
module uart_seq_checker_rx_core
  import uart_seq_checker_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY       = PARITY_NONE,
  parameter int STOP_BITS    = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  valid,
  output logic                  frame_err,
  output logic                  parity_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [CW-1:0] CNT_FULL  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_WIDTH - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
  localparam logic [BW-1:0] BIT_ONE   = BW'(1);

  rx_state_e             state_q, state_d;
  logic                  sync1_q, sync1_d;
  logic                  sync2_q, sync2_d;
  logic                  rx_prev_q, rx_prev_d;
  logic                  pend_q, pend_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  ferr_q, ferr_d;
  logic                  perr_q, perr_d;
  logic                  fall;

  assign fall = rx_prev_q & ~sync2_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
      pend_q    <= 1'b0;
      cnt_q     <= '0;
      bit_q     <= '0;
      shreg_q   <= '0;
      data_q    <= '0;
      ferr_q    <= 1'b0;
      perr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      rx_prev_q <= rx_prev_d;
      pend_q    <= pend_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shreg_q   <= shreg_d;
      data_q    <= data_d;
      ferr_q    <= ferr_d;
      perr_q    <= perr_d;
    end
  end

  always_comb begin
    sync1_d   = rx;
    sync2_d   = sync1_q;
    rx_prev_d = sync2_q;
    state_d   = state_q;
    pend_d    = pend_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    shreg_d   = shreg_q;
    data_d    = data_q;
    ferr_d    = ferr_q;
    perr_d    = perr_q;

    unique case (state_q)
      ST_IDLE: begin
        if (fall || pend_q) begin
          state_d = ST_START;
          pend_d  = 1'b0;
          // an edge held over from CHECK is one cycle old, so shorten the half-bit wait
          cnt_d   = pend_q ? (CNT_HALF - CNT_ONE) : CNT_HALF;
        end
      end
      ST_START: begin
        if (cnt_q == '0) begin
          if (sync2_q) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_DATA;
            cnt_d   = CNT_FULL;
            bit_d   = '0;
            ferr_d  = 1'b0;
            perr_d  = 1'b0;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_DATA: begin
        if (cnt_q == '0) begin
          shreg_d = {sync2_q, shreg_q[DATA_WIDTH-1:1]};
          cnt_d   = CNT_FULL;
          if (bit_q == BIT_LAST) begin
            bit_d   = '0;
            state_d = (PARITY != PARITY_NONE) ? ST_PAR : ST_STOP;
          end else begin
            bit_d = bit_q + BIT_ONE;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_PAR: begin
        if (cnt_q == '0) begin
          perr_d  = parity_bad(PARITY, (^shreg_q) ^ sync2_q);
          cnt_d   = CNT_FULL;
          bit_d   = '0;
          state_d = ST_STOP;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_STOP: begin
        if (cnt_q == '0) begin
          ferr_d = ferr_q | ~sync2_q;
          if (bit_q == STOP_LAST) begin
            state_d = ST_CHECK;
            data_d  = shreg_q;
          end else begin
            bit_d = bit_q + BIT_ONE;
            cnt_d = CNT_FULL;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_CHECK: begin
        state_d = ST_IDLE;
        pend_d  = fall;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    valid      = (state_q == ST_CHECK);
    frame_err  = valid & ferr_q;
    parity_err = valid & perr_q;
    data       = data_q;
  end

endmodule

// File: rtl/uart_seq_checker.sv
// Self-test top: UART receiver feeding a Fibonacci expected-value checker that
// produces a sticky pass/fail verdict.
module uart_seq_checker
  import uart_seq_checker_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY       = PARITY_NONE,
  parameter int STOP_BITS    = 1,
  parameter int EXPECT_CNT   = 12
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            rx,
  output logic [DATA_WIDTH-1:0]           rx_data,
  output logic                            rx_valid,
  output logic                            frame_err,
  output logic                            parity_err,
  output logic                            mismatch,
  output logic [$clog2(EXPECT_CNT+1)-1:0] fail_idx,
  output logic [$clog2(EXPECT_CNT+1)-1:0] match_cnt,
  output logic                            done,
  output logic                            pass
);

  localparam int CNTW = $clog2(EXPECT_CNT + 1);

  localparam logic [CNTW-1:0]       CNT_ONE = CNTW'(1);
  localparam logic [CNTW-1:0]       CNT_EXP = CNTW'(EXPECT_CNT);
  localparam logic [DATA_WIDTH-1:0] FIB_ONE = DATA_WIDTH'(1);

  logic rx_ferr, rx_perr;

  logic [DATA_WIDTH-1:0] cur_q, cur_d;
  logic [DATA_WIDTH-1:0] prev_q, prev_d;
  logic [CNTW-1:0]       match_cnt_q, match_cnt_d;
  logic [CNTW-1:0]       fail_idx_q, fail_idx_d;
  logic                  mismatch_q, mismatch_d;
  logic                  frame_err_q, frame_err_d;
  logic                  parity_err_q, parity_err_d;
  logic                  done_q, done_d;
  logic                  pass_q, pass_d;

  uart_seq_checker_rx_core #(
    .DATA_WIDTH  (DATA_WIDTH),
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .PARITY      (PARITY),
    .STOP_BITS   (STOP_BITS)
  ) u_rx_core (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .data      (rx_data),
    .valid     (rx_valid),
    .frame_err (rx_ferr),
    .parity_err(rx_perr)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      cur_q        <= FIB_ONE;
      prev_q       <= '0;
      match_cnt_q  <= '0;
      fail_idx_q   <= '0;
      mismatch_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
    end else begin
      cur_q        <= cur_d;
      prev_q       <= prev_d;
      match_cnt_q  <= match_cnt_d;
      fail_idx_q   <= fail_idx_d;
      mismatch_q   <= mismatch_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
    end
  end

  // Once a verdict is reached everything here freezes; the receiver keeps running.
  always_comb begin
    cur_d        = cur_q;
    prev_d       = prev_q;
    match_cnt_d  = match_cnt_q;
    fail_idx_d   = fail_idx_q;
    mismatch_d   = mismatch_q;
    frame_err_d  = frame_err_q;
    parity_err_d = parity_err_q;
    done_d       = done_q;
    pass_d       = pass_q;

    if (rx_valid && !done_q) begin
      if (rx_ferr || rx_perr) begin
        frame_err_d  = frame_err_q | rx_ferr;
        parity_err_d = parity_err_q | rx_perr;
        done_d       = 1'b1;
        fail_idx_d   = match_cnt_q;
      end else if (rx_data == cur_q) begin
        match_cnt_d = match_cnt_q + CNT_ONE;
        cur_d       = cur_q + prev_q;
        prev_d      = cur_q;
        if (match_cnt_d == CNT_EXP) begin
          done_d = 1'b1;
          pass_d = 1'b1;
        end
      end else begin
        mismatch_d = 1'b1;
        done_d     = 1'b1;
        fail_idx_d = match_cnt_q;
      end
    end
  end

  assign match_cnt  = match_cnt_q;
  assign fail_idx   = fail_idx_q;
  assign mismatch   = mismatch_q;
  assign frame_err  = frame_err_q;
  assign parity_err = parity_err_q;
  assign done       = done_q;
  assign pass       = pass_q;

endmodule

// File: tb/tb_uart_seq_checker.sv
// Directed bench for uart_seq_checker: 8N1 instance plus an even-parity instance
// with EXPECT_CNT=3, driven bit by bit at CLKS_PER_BIT clocks per bit.
module tb_uart_seq_checker;

  localparam int CPB = 4;

  logic clk = 1'b0;
  logic reset;
  logic rx_a, rx_b;

  logic [7:0] a_rx_data;
  logic       a_valid, a_frame_err, a_parity_err, a_mismatch, a_done, a_pass;
  logic [3:0] a_fail_idx, a_match_cnt;

  logic [7:0] b_rx_data;
  logic       b_valid, b_frame_err, b_parity_err, b_mismatch, b_done, b_pass;
  logic [1:0] b_fail_idx, b_match_cnt;

  int n_vec = 0;
  int n_err = 0;
  int vcnt_a = 0;
  int vcnt_b = 0;
  int base;

  logic [7:0] fib [0:11] = '{8'd1, 8'd1, 8'd2, 8'd3, 8'd5, 8'd8,
                             8'd13, 8'd21, 8'd34, 8'd55, 8'd89, 8'd144};

  uart_seq_checker #(
    .DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY(0), .STOP_BITS(1), .EXPECT_CNT(12)
  ) dut_a (
    .clk(clk), .reset(reset), .rx(rx_a),
    .rx_data(a_rx_data), .rx_valid(a_valid), .frame_err(a_frame_err),
    .parity_err(a_parity_err), .mismatch(a_mismatch), .fail_idx(a_fail_idx),
    .match_cnt(a_match_cnt), .done(a_done), .pass(a_pass)
  );

  uart_seq_checker #(
    .DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY(1), .STOP_BITS(1), .EXPECT_CNT(3)
  ) dut_b (
    .clk(clk), .reset(reset), .rx(rx_b),
    .rx_data(b_rx_data), .rx_valid(b_valid), .frame_err(b_frame_err),
    .parity_err(b_parity_err), .mismatch(b_mismatch), .fail_idx(b_fail_idx),
    .match_cnt(b_match_cnt), .done(b_done), .pass(b_pass)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (a_valid) vcnt_a++;
    if (b_valid) vcnt_b++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_bit(input logic v, input bit to_b);
    if (to_b) rx_b = v;
    else      rx_a = v;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit to_b, input bit with_par,
                            input bit par_flip, input logic stop_val);
    @(negedge clk);
    drive_bit(1'b0, to_b);
    for (int i = 0; i < 8; i++) drive_bit(b[i], to_b);
    if (with_par) drive_bit((^b) ^ par_flip, to_b);
    drive_bit(stop_val, to_b);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    rx_a  = 1'b1;
    rx_b  = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    rx_a  = 1'b1;
    rx_b  = 1'b1;
    do_reset();

    // reset state
    check("rst_rx_data",   32'(a_rx_data), 0);
    check("rst_valid",     32'(a_valid), 0);
    check("rst_flags",     32'({a_frame_err, a_parity_err, a_mismatch, a_done, a_pass}), 0);
    check("rst_fail_idx",  32'(a_fail_idx), 0);
    check("rst_match_cnt", 32'(a_match_cnt), 0);
    check("rst_b_flags",   32'({b_frame_err, b_parity_err, b_mismatch, b_done, b_pass}), 0);

    // full correct sequence, frames back to back
    base = vcnt_a;
    for (int i = 0; i < 12; i++) send_frame(fib[i], 1'b0, 1'b0, 1'b0, 1'b1);
    idle(4);
    check("s1_valid_cnt", vcnt_a - base, 12);
    check("s1_match_cnt", 32'(a_match_cnt), 12);
    check("s1_done",      32'(a_done), 1);
    check("s1_pass",      32'(a_pass), 1);
    check("s1_err_flags", 32'({a_frame_err, a_parity_err, a_mismatch}), 0);
    check("s1_rx_data",   32'(a_rx_data), 32'h90);
    send_frame(8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(4);
    check("s1_post_valid", vcnt_a - base, 13);
    check("s1_post_data",  32'(a_rx_data), 0);
    check("s1_post_match", 32'(a_match_cnt), 12);
    check("s1_post_pass",  32'({a_done, a_pass, a_mismatch}), 32'b110);

    // wrong 4th value
    do_reset();
    send_frame(8'd1, 1'b0, 1'b0, 1'b0, 1'b1);
    send_frame(8'd1, 1'b0, 1'b0, 1'b0, 1'b1);
    send_frame(8'd2, 1'b0, 1'b0, 1'b0, 1'b1);
    send_frame(8'd4, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(4);
    check("s2_mismatch",  32'(a_mismatch), 1);
    check("s2_done",      32'(a_done), 1);
    check("s2_pass",      32'(a_pass), 0);
    check("s2_fail_idx",  32'(a_fail_idx), 3);
    check("s2_match_cnt", 32'(a_match_cnt), 3);
    base = vcnt_a;
    send_frame(8'h05, 1'b0, 1'b0, 1'b0, 1'b1);
    check("s2_lat_before", 32'(a_valid), 0);
    @(posedge clk); #1;
    check("s2_lat_valid",  32'(a_valid), 1);
    check("s2_lat_data",   32'(a_rx_data), 5);
    idle(4);
    check("s2_post_cnt",   vcnt_a - base, 1);
    check("s2_post_match", 32'(a_match_cnt), 3);
    check("s2_post_idx",   32'(a_fail_idx), 3);

    // stop bit sampled low
    do_reset();
    send_frame(8'h01, 1'b0, 1'b0, 1'b0, 1'b0);
    rx_a = 1'b1;
    idle(4);
    check("s3_frame_err", 32'(a_frame_err), 1);
    check("s3_done",      32'(a_done), 1);
    check("s3_pass",      32'(a_pass), 0);
    check("s3_fail_idx",  32'(a_fail_idx), 0);
    check("s3_match_cnt", 32'(a_match_cnt), 0);
    check("s3_mismatch",  32'(a_mismatch), 0);

    // break: line held low for 20 bit times gives exactly one bad frame
    do_reset();
    base = vcnt_a;
    rx_a = 1'b0;
    idle(20 * CPB);
    check("brk_valid_cnt", vcnt_a - base, 1);
    check("brk_frame_err", 32'(a_frame_err), 1);
    check("brk_rx_data",   32'(a_rx_data), 0);
    rx_a = 1'b1;
    idle(8);
    check("brk_release_cnt", vcnt_a - base, 1);

    // one-clock glitch is a false start
    do_reset();
    base = vcnt_a;
    rx_a = 1'b0;
    @(negedge clk);
    rx_a = 1'b1;
    idle(20);
    check("s4_glitch_cnt",   vcnt_a - base, 0);
    check("s4_glitch_flags", 32'({a_frame_err, a_done}), 0);
    send_frame(8'h01, 1'b0, 1'b0, 1'b0, 1'b1);
    check("s4_lat_before", 32'(a_valid), 0);
    @(posedge clk); #1;
    check("s4_lat_valid",  32'(a_valid), 1);
    check("s4_lat_data",   32'(a_rx_data), 1);
    idle(4);
    check("s4_valid_cnt",  vcnt_a - base, 1);
    check("s4_match_cnt",  32'(a_match_cnt), 1);
    check("s4_done",       32'(a_done), 0);

    // even parity instance: third frame carries a flipped parity bit
    do_reset();
    base = vcnt_b;
    send_frame(8'd1, 1'b1, 1'b1, 1'b0, 1'b1);
    send_frame(8'd1, 1'b1, 1'b1, 1'b0, 1'b1);
    idle(4);
    check("s5_good_match", 32'(b_match_cnt), 2);
    check("s5_good_perr",  32'(b_parity_err), 0);
    send_frame(8'd2, 1'b1, 1'b1, 1'b1, 1'b1);
    idle(4);
    check("s5_valid_cnt",  vcnt_b - base, 3);
    check("s5_parity_err", 32'(b_parity_err), 1);
    check("s5_fail_idx",   32'(b_fail_idx), 2);
    check("s5_pass",       32'(b_pass), 0);
    check("s5_done",       32'(b_done), 1);
    check("s5_match_cnt",  32'(b_match_cnt), 2);
    check("s5_other",      32'({b_frame_err, b_mismatch}), 0);
    check("s5_rx_data",    32'(b_rx_data), 2);

    // reset in the middle of the data bits of frame 2
    do_reset();
    base = vcnt_a;
    send_frame(8'd1, 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    drive_bit(1'b0, 1'b0);
    drive_bit(1'b1, 1'b0);
    drive_bit(1'b0, 1'b0);
    reset = 1'b1;
    rx_a  = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    idle(20);
    check("s6_abort_cnt",  vcnt_a - base, 1);
    check("s6_rst_match",  32'(a_match_cnt), 0);
    check("s6_rst_flags",  32'({a_frame_err, a_parity_err, a_mismatch, a_done, a_pass}), 0);
    check("s6_rst_data",   32'(a_rx_data), 0);
    for (int i = 0; i < 12; i++) send_frame(fib[i], 1'b0, 1'b0, 1'b0, 1'b1);
    idle(4);
    check("s6_valid_cnt",  vcnt_a - base, 13);
    check("s6_match_cnt",  32'(a_match_cnt), 12);
    check("s6_pass",       32'({a_done, a_pass}), 32'b11);
    check("s6_err_flags",  32'({a_frame_err, a_parity_err, a_mismatch}), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
